// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel printer and video DAC.
// No backpressure: a new point is presented on every vga_clk cycle and video_on qualifies pixel_x/pixel_y.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       blank_n;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  modport master (
    output hsync, vsync, video_on, blank_n, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, video_on, blank_n, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters with a registered decode of sync, blanking and coordinates.
// Every output is registered from the same (h,v) point, so all outputs lag the counters by one cycle together.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input  logic             vga_clk,
  input  logic             rst,
  vga_timing_gen_if.master o_vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Decode boundaries are 11 bits so a region edge at 1024 still compares correctly.
  localparam logic [10:0] H_DISP_END   = 11'(H_DISPLAY);
  localparam logic [10:0] H_SYNC_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_DISP_END   = 11'(V_DISPLAY);
  localparam logic [10:0] V_SYNC_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0]  H_MAX        = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX        = 10'(V_TOTAL - 1);

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
    $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_video_on;
  logic [9:0]  r_pixel_x;
  logic [9:0]  r_pixel_y;
  logic        r_line_start;
  logic        r_frame_start;

  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_video_on;
  logic        w_hs_active;
  logic        w_vs_active;

  always_comb begin
    w_h_ext     = {1'b0, r_h_cnt};
    w_v_ext     = {1'b0, r_v_cnt};
    w_h_wrap    = (r_h_cnt == H_MAX);
    w_v_wrap    = (r_v_cnt == V_MAX);
    w_video_on  = (w_h_ext < H_DISP_END) && (w_v_ext < V_DISP_END);
    w_hs_active = (w_h_ext >= H_SYNC_START) && (w_h_ext < H_SYNC_END);
    w_vs_active = (w_v_ext >= V_SYNC_START) && (w_v_ext < V_SYNC_END);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (w_h_wrap) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= w_v_wrap ? 10'd0 : (r_v_cnt + 10'd1);
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Reset parks the syncs at their inactive level so no partial pulse survives a mid-frame reset.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_video_on    <= 1'b0;
      r_pixel_x     <= 10'd0;
      r_pixel_y     <= 10'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hs_active ? H_POL : ~H_POL;
      r_vsync       <= w_vs_active ? V_POL : ~V_POL;
      r_video_on    <= w_video_on;
      r_pixel_x     <= r_h_cnt;
      r_pixel_y     <= r_v_cnt;
      r_line_start  <= (r_h_cnt == 10'd0);
      r_frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    end
  end

  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.video_on    = r_video_on;
  assign o_vga.blank_n     = r_video_on;
  assign o_vga.pixel_x     = r_pixel_x;
  assign o_vga.pixel_y     = r_pixel_y;
  assign o_vga.line_start  = r_line_start;
  assign o_vga.frame_start = r_frame_start;

endmodule
